// File: rtl/myproject_mac_pipe.sv
// Pipelined signed MAC: ACC_LEN products plus bias per window, >>> FRAC_SHIFT, narrowed to DOUT_WIDTH.
// Latency NUM_STAGE edges from last accept to out_valid; a held result (out_valid & ~out_ready) freezes the whole pipe.
// Define MYPROJECT_MAC_SAT_EN to saturate the result and flag clipping on sat; otherwise the result wraps.
module myproject_mac_pipe #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 6,
    parameter int ACC_WIDTH  = 20,
    parameter int DOUT_WIDTH = 13,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_LEN    = 25,
    parameter int FRAC_SHIFT = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int L  = NUM_STAGE - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACC_LEN - 1);

    logic stall;
    logic accept;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = !accept ? cnt_q : ((cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Bias rides alongside each product so back-to-back windows never share a capture register.
    logic [NUM_STAGE-1:0]        vld_q, first_q, last_q;
    logic signed [PW-1:0]        prod_q [NUM_STAGE];
    logic signed [ACC_WIDTH-1:0] bias_q [NUM_STAGE];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
                bias_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0]   <= accept;
            first_q[0] <= accept && (cnt_q == '0);
            last_q[0]  <= accept && (cnt_q == LAST_CNT);
            prod_q[0]  <= PW'($signed(din0)) * PW'($signed(din1));
            bias_q[0]  <= $signed(bias);
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                prod_q[i]  <= prod_q[i-1];
                bias_q[i]  <= bias_q[i-1];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext;
    assign prod_ext = ACC_WIDTH'(prod_q[L]);
    assign acc_d    = first_q[L] ? (bias_q[L] + prod_ext) : (acc_q + prod_ext);

    logic [DOUT_WIDTH-1:0] narrow_dat;
    logic                  narrow_sat;

`ifdef MYPROJECT_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] DMAX = ACC_WIDTH'((64'sd1 <<< (DOUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] DMIN = ~DMAX;
    logic signed [ACC_WIDTH-1:0] r;
    assign r = acc_d >>> FRAC_SHIFT;

    always_comb begin
        narrow_dat = r[DOUT_WIDTH-1:0];
        narrow_sat = 1'b0;
        if (r > DMAX) begin
            narrow_dat = DMAX[DOUT_WIDTH-1:0];
            narrow_sat = 1'b1;
        end else if (r < DMIN) begin
            narrow_dat = DMIN[DOUT_WIDTH-1:0];
            narrow_sat = 1'b1;
        end
    end
`else
    // Dropping the low FRAC_SHIFT bits is the floor shift; keeping DOUT_WIDTH bits above is the wrap.
    assign narrow_dat = acc_d[FRAC_SHIFT +: DOUT_WIDTH];
    assign narrow_sat = 1'b0;
`endif

    logic                  out_valid_q, sat_q;
    logic [DOUT_WIDTH-1:0] dout_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_q       <= '0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (!stall && vld_q[L]) acc_q <= acc_d;
            if (!stall && vld_q[L] && last_q[L]) begin
                dout_q      <= narrow_dat;
                sat_q       <= narrow_sat;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: default instance (a_*) plus ACC_LEN=1/NUM_STAGE=1 instance (b_*), window-sum reference model.
module tb_myproject_mac_pipe;
    localparam int D0 = 8, D1 = 6, AW = 20, DW = 13, FS = 4;
    localparam int NSA = 2, ALA = 25, NSB = 1, ALB = 1;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    logic                 a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_sat;
    logic signed [D0-1:0] a_din0 = '0;
    logic signed [D1-1:0] a_din1 = '0;
    logic signed [AW-1:0] a_bias = '0;
    logic signed [DW-1:0] a_dout;
    logic                 b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_sat;
    logic signed [D0-1:0] b_din0 = '0;
    logic signed [D1-1:0] b_din1 = '0;
    logic signed [AW-1:0] b_bias = '0;
    logic signed [DW-1:0] b_dout;

    myproject_mac_pipe u_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din0(a_din0), .din1(a_din1), .bias(a_bias), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .dout(a_dout), .sat(a_sat)
    );

    myproject_mac_pipe #(.NUM_STAGE(NSB), .ACC_LEN(ALB)) u_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din0(b_din0), .din1(b_din1), .bias(b_bias), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .dout(b_dout), .sat(b_sat)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole-window integer sums, floor division, then clamp or modular wrap.
    typedef struct { int dout; bit sat; int due; } res_t;
    res_t   qa[$], qb[$];
    longint suma = 0, sumb = 0;
    int     cnta = 0, cntb = 0;
    bit     lat_a = 0, lat_b = 0, seen_a = 0, seen_b = 0, acc_a = 0;

    function automatic res_t mk(longint s, int due);
        res_t   x;
        longint r, lim, div;
        lim = longint'(1) <<< (DW - 1);
        div = longint'(1) <<< FS;
        r = (s >= 0) ? s / div : -((-s + div - 1) / div);
`ifdef MYPROJECT_MAC_SAT_EN
        if (r > lim - 1)   begin x.dout = int'(lim - 1); x.sat = 1; end
        else if (r < -lim) begin x.dout = int'(-lim);    x.sat = 1; end
        else               begin x.dout = int'(r);       x.sat = 0; end
`else
        r = r % (2 * lim);
        if (r < 0)    r += 2 * lim;
        if (r >= lim) r -= 2 * lim;
        x.dout = int'(r);
        x.sat  = 0;
`endif
        x.due = due;
        return x;
    endfunction

    // Stimulus registers applied at the next negedge by step().
    bit s_av = 0, s_ar = 1, s_bv = 0, s_br = 1;
    int s_a0 = 0, s_a1 = 0, s_ab = 0, s_b0 = 0, s_b1 = 0, s_bb = 0;

    task automatic step();
        @(negedge ap_clk);
        a_in_valid = s_av; a_din0 = D0'(s_a0); a_din1 = D1'(s_a1); a_bias = AW'(s_ab); a_out_ready = s_ar;
        b_in_valid = s_bv; b_din0 = D0'(s_b0); b_din1 = D1'(s_b1); b_bias = AW'(s_bb); b_out_ready = s_br;
        #1;
        chk("a_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
        chk("b_in_ready", b_in_ready, !(b_out_valid && !b_out_ready));
        if (a_out_valid) begin
            if (qa.size() == 0) chk("a_spurious_vld", a_out_valid, 0);
            else begin
                chk("a_dout", a_dout, qa[0].dout);
                chk("a_sat", a_sat, qa[0].sat);
                if (lat_a && !seen_a) chk("a_latency", cyc, qa[0].due);
                seen_a = 1;
                if (a_out_ready) begin void'(qa.pop_front()); seen_a = 0; end
            end
        end
        if (b_out_valid) begin
            if (qb.size() == 0) chk("b_spurious_vld", b_out_valid, 0);
            else begin
                chk("b_dout", b_dout, qb[0].dout);
                chk("b_sat", b_sat, qb[0].sat);
                if (lat_b && !seen_b) chk("b_latency", cyc, qb[0].due);
                seen_b = 1;
                if (b_out_ready) begin void'(qb.pop_front()); seen_b = 0; end
            end
        end
        acc_a = a_in_valid && a_in_ready;
        if (acc_a) begin
            if (cnta == 0) suma = longint'(a_bias);
            suma += longint'(a_din0) * longint'(a_din1);
            cnta++;
            if (cnta == ALA) begin qa.push_back(mk(suma, cyc + 1 + NSA)); cnta = 0; end
        end
        if (b_in_valid && b_in_ready) begin
            if (cntb == 0) sumb = longint'(b_bias);
            sumb += longint'(b_din0) * longint'(b_din1);
            cntb++;
            if (cntb == ALB) begin qb.push_back(mk(sumb, cyc + 1 + NSB)); cntb = 0; end
        end
    endtask

    task automatic idle(input int n);
        s_av = 0; s_bv = 0; s_ar = 1; s_br = 1;
        repeat (n) step();
        chk("a_drained", qa.size(), 0);
        chk("b_drained", qb.size(), 0);
    endtask

    task automatic reset_pulse();
        @(negedge ap_clk);
        ap_rst = 1; a_in_valid = 0; b_in_valid = 0;
        repeat (2) begin
            #1;
            chk("rst_a_vld", a_out_valid, 0);
            chk("rst_a_dout", a_dout, 0);
            chk("rst_a_sat", a_sat, 0);
            chk("rst_b_vld", b_out_valid, 0);
            @(negedge ap_clk);
        end
        ap_rst = 0;
        qa.delete(); qb.delete();
        cnta = 0; cntb = 0; seen_a = 0; seen_b = 0;
    endtask

    task automatic window_a(input int a0, input int a1, input int ab);
        s_av = 1; s_a0 = a0; s_a1 = a1; s_ab = ab; s_ar = 1;
        repeat (ALA) step();
        s_av = 0;
    endtask

    initial begin
        int sent, hold;
        reset_pulse();

        lat_a = 1;
        window_a(16, 16, 0);
        idle(6);
        window_a(127, 31, 0);
        idle(5);
        window_a(-128, 31, 0);
        idle(5);
        window_a(0, 0, -16);
        idle(5);

        // Two back-to-back windows with a 5-cycle hold on the first result.
        lat_a = 0; sent = 0; hold = -1;
        for (int i = 0; i < 90; i++) begin
            s_ar = 1;
            if (hold < 0 && a_out_valid) hold = 5;
            if (hold > 0) begin s_ar = 0; hold--; end
            s_av = (sent < 2 * ALA); s_a0 = 16; s_a1 = 16; s_ab = 0;
            step();
            if (acc_a) sent++;
        end
        chk("t4_sent", sent, 2 * ALA);
        idle(5);

        // Abort a window with reset after 10 accepts, then a clean window.
        s_av = 1; s_a0 = 16; s_a1 = 16; s_ab = 0;
        repeat (10) step();
        reset_pulse();
        lat_a = 1;
        window_a(16, 16, 0);
        idle(6);

        // ACC_LEN=1 stream: one result per cycle.
        lat_b = 1;
        s_bv = 1; s_b0 = 16; s_b1 = -16; s_bb = 32; s_br = 1;
        repeat (20) step();
        idle(4);

        // Randomised traffic on both instances with random backpressure.
        lat_a = 0; lat_b = 0;
        for (int i = 0; i < 400; i++) begin
            s_av = ($urandom_range(0, 3) != 0);
            s_a0 = int'($urandom_range(0, 255)) - 128;
            s_a1 = int'($urandom_range(0, 63)) - 32;
            s_ab = int'($urandom_range(0, 60000)) - 30000;
            s_ar = ($urandom_range(0, 9) < 7);
            s_bv = ($urandom_range(0, 3) != 0);
            s_b0 = int'($urandom_range(0, 255)) - 128;
            s_b1 = int'($urandom_range(0, 63)) - 32;
            s_bb = int'($urandom_range(0, 4000)) - 2000;
            s_br = ($urandom_range(0, 9) < 7);
            step();
        end
        s_av = 0; s_bv = 0;
        // Finish any partial window so the drain check is exact.
        while (cnta != 0) begin
            s_av = 1; s_a0 = 3; s_a1 = -5; s_ab = 7; s_ar = 1;
            step();
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/myproject_mac_pipe.md
Name: myproject_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit; successor to the single-cycle combinational signed multipliers in the generated LeNet-5 datapath.
- Multiplies a stream of (din0, din1) pairs and accumulates ACC_LEN products plus a bias.
- Rescales the sum by FRAC_SHIFT and emits one DOUT_WIDTH result per window.
- Sits between the line-buffer/weight fetch and the activation stage of each conv/dense layer, with valid/ready handshakes on both sides.

Parameters:
DIN0_WIDTH, 8, signed activation width (ap_fixed<8,4>)
DIN1_WIDTH, 6, signed weight width
ACC_WIDTH, 20, signed accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH+clog2(ACC_LEN)
DOUT_WIDTH, 13, signed result width
NUM_STAGE, 2, multiplier pipeline register stages, ≥1
ACC_LEN, 25, products per output (5x5 kernel); ≥1
FRAC_SHIFT, 4, arithmetic right shift applied to final sum

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  unit can accept operands this cycle
din0  in  DIN0_WIDTH  signed activation
din1  in  DIN1_WIDTH  signed weight
bias  in  ACC_WIDTH  signed bias, in product scale; sampled with first element of each window
out_valid  out  1  dout holds a result
out_ready  in  1  downstream accepts dout
dout  out  DOUT_WIDTH  signed result
sat  out  1  dout was clipped; qualified by out_valid

Behaviour:
- Reset (async assert, sync deassert by design): all stage valids=0, element counter=0, accumulator=0, dout=0, out_valid=0, sat=0.
- Stall condition: stall = out_valid & ~out_ready.
- in_ready = ~stall, combinational. It is 1 out of reset.
- Pipeline advances only when ~stall. Stalled stages hold data and valid bits unchanged.
- Accept: in_valid & in_ready at edge k.
  - Product = $signed(din0)*$signed(din1), full DIN0_WIDTH+DIN1_WIDTH bits, registered at edge k.
  - Product shifts through NUM_STAGE stages, carrying its own valid and first/last tags.
- First/last tags come from an element counter, 0..ACC_LEN-1, incremented on each accept.
  - Counter wraps to 0 after ACC_LEN-1.
  - first = (count==0); last = (count==ACC_LEN-1). With ACC_LEN=1, both are set.
- Accumulate stage (final pipeline stage, valid):
  - If first: acc <= sext(bias_captured) + sext(product).
  - Otherwise: acc <= acc + sext(product).
  - Accumulator arithmetic wraps at ACC_WIDTH; the parameter rule guarantees no overflow.
- On last, output register loads in the same edge that completes the sum:
  - r = (acc_next) >>> FRAC_SHIFT, floor/truncate toward -inf.
  - dout = narrow(r) (see Optional Feature); out_valid <= 1.
- Latency: last element accepted at edge k → out_valid=1 after edge k+NUM_STAGE.
- Throughput: 1 element/cycle when out_ready held high.
- out_valid clears on out_valid & out_ready unless a new result loads on the same edge. If both occur, the new result overwrites with out_valid staying 1.
- dout/sat hold their value while out_valid & ~out_ready.
- Bias capture: bias is registered at first accept and travels with the first tag; bias changes mid-window are ignored.
- Reset mid-window: partial sum, counter and in-flight products are discarded; the next accept is treated as first.

Optional Feature:
Macro MYPROJECT_MAC_SAT_EN.
- Defined: narrow() saturates r to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; sat=1 when clipped, else 0.
- Undefined: narrow() keeps the low DOUT_WIDTH bits (two's-complement wrap, matching ap_fixed AP_WRAP); sat tied 0.

Test Plan:
1. Defaults, bias=0, 25 pairs din0=16, din1=16, out_ready=1 → dout=400, sat=0; out_valid exactly 1 cycle, 2 cycles after last accept edge (NUM_STAGE=2).
2. 25 pairs din0=127, din1=31, bias=0 → sum 98425, r=6151. With MAC_SAT_EN: dout=4095, sat=1. Without: dout=-2041, sat=0.
3. 25 pairs din0=-128, din1=31, bias=0 → r=-6200. With MAC_SAT_EN: dout=-4096, sat=1. Also bias=-16, one window din0=din1=0 → dout=-1 (floor).
4. Back-to-back windows of test 1 with out_ready=0 for 5 cycles after first result → in_ready=0 during stall, dout=400 held. Second result 400 follows with no lost or duplicated element.
5. ap_rst pulsed after 10 of 25 accepts, then a full 25-pair window of test 1 → single dout=400; no output from the aborted window; all outputs 0 during reset.
6. ACC_LEN=1, NUM_STAGE=1, bias=32, stream din0=16, din1=-16 every cycle → dout=-14 each cycle, out_valid continuously 1.
